// File: rtl/glorb_pkg.sv
// Shared definitions for the instruction-memory responder: FSM states,
// the NOP encoding and the chunks-per-word derivation.
package glorb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    START = 2'd2,
    RUN   = 2'd3
  } state_t;

  // All-zero word; the fetch register shows this whenever nothing valid is held.
  localparam logic [31:0] NOP_WORD = 32'h0;

  // Number of load chunks that make up one instruction word.
  function automatic int calc_cpw(input int iw, input int lw);
    return iw / lw;
  endfunction

  // A word must split into a whole number of non-empty chunks.
  function automatic bit width_ok(input int iw, input int lw);
    return (lw > 0) && (iw >= lw) && ((iw % lw) == 0);
  endfunction

endpackage

// File: rtl/imem_responder_if.sv
// Fetch and program-load bus of the instruction-memory responder.
// master = loader/host plus core side, slave = the responder.
interface imem_responder_if #(
  parameter int IW  = 12,
  parameter int IMW = 4,
  parameter int LW  = 4
);
  logic           ld_valid;
  logic           ld_ready;
  logic [LW-1:0]  ld_data;
  logic           ld_last;
  logic           reload;
  logic [IMW-1:0] pc_addr;
  logic [IW-1:0]  instr;
  logic           instr_valid;
  logic           start;
  logic           load_err;

  modport master (
    output ld_valid, ld_data, ld_last, reload, pc_addr,
    input  ld_ready, instr, instr_valid, start, load_err
  );

  modport slave (
    input  ld_valid, ld_data, ld_last, reload, pc_addr,
    output ld_ready, instr, instr_valid, start, load_err
  );
endinterface

// File: rtl/imem_responder_word_asm.sv
// Chunk assembler: shifts load chunks in MSB-first and flags the chunk that
// completes a word. The completed word is presented combinationally so the
// parent can write it to memory on the same edge that accepts the last chunk.
module imem_word_asm
  import glorb_pkg::*;
#(
  parameter int IW = 12,
  parameter int LW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          chunk_valid,
  input  logic [LW-1:0] chunk_data,
  output logic          word_done,
  output logic [IW-1:0] word
);

  localparam int CPW = calc_cpw(IW, LW);
  localparam int CW  = (CPW > 1) ? $clog2(CPW) : 1;

  if (!width_ok(IW, LW)) begin : g_bad_width
    $error("imem_word_asm: IW must be a non-zero multiple of LW");
  end

  logic [CW-1:0] cnt;
  logic [IW-1:0] shift;
  logic          at_last;

  assign at_last   = (cnt == CW'(CPW - 1));
  assign word_done = chunk_valid && at_last;
  assign word      = IW'({shift, chunk_data});

  // Shift each accepted chunk in and count position within the current word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      shift <= '0;
    end else if (clear) begin
      cnt   <= '0;
      shift <= '0;
    end else if (chunk_valid) begin
      shift <= IW'({shift, chunk_data});
      cnt   <= at_last ? '0 : cnt + CW'(1);
    end
  end

endmodule

// File: rtl/imem_responder.sv
// Instruction-memory responder: loads a program nibble-serially, pulses start
// once loaded, then answers fetch addresses with a registered instruction.
module imem_responder
  import glorb_pkg::*;
#(
  parameter int IW  = 12,
  parameter int IMW = 4,
  parameter int LW  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  imem_responder_if.slave  bus
);

  localparam int DEPTH = 2 ** IMW;

  if (!width_ok(IW, LW)) begin : g_bad_width
    $error("imem_responder: IW must be a non-zero multiple of LW");
  end

  state_t        state;
  logic [IW-1:0] mem [DEPTH];
  logic [IMW:0]  wr_cnt;
  logic          full;
  logic          accept;
  logic          wr_en;
  logic          asm_clear;
  logic          word_done;
  logic [IW-1:0] word;

  assign full      = wr_cnt[IMW];
  assign accept    = bus.ld_valid && bus.ld_ready && (state == IDLE || state == LOAD);
  assign wr_en     = accept && word_done && !full;
  assign asm_clear = (state == RUN) && bus.reload;

  imem_word_asm #(.IW(IW), .LW(LW)) u_asm (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear       (asm_clear),
    .chunk_valid (accept),
    .chunk_data  (bus.ld_data),
    .word_done   (word_done),
    .word        (word)
  );

  // Program storage; deliberately not reset so a reset does not cost a reload.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_cnt[IMW-1:0]] <= word;
    end
  end

  // Load/start/run sequencing with all bus outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      wr_cnt          <= '0;
      bus.ld_ready    <= 1'b1;
      bus.instr       <= IW'(NOP_WORD);
      bus.instr_valid <= 1'b0;
      bus.start       <= 1'b0;
      bus.load_err    <= 1'b0;
    end else begin
      case (state)
        IDLE, LOAD: begin
          if (accept) begin
            state <= LOAD;
            if (word_done) begin
              if (full) begin
                bus.load_err <= 1'b1;
              end else begin
                wr_cnt <= wr_cnt + 1'b1;
              end
            end
            if (bus.ld_last) begin
              if (!word_done) begin
                bus.load_err <= 1'b1;
              end
              state        <= START;
              bus.ld_ready <= 1'b0;
              bus.start    <= 1'b1;
            end
          end
        end
        START: begin
          bus.start <= 1'b0;
          state     <= RUN;
        end
        RUN: begin
          if (bus.reload) begin
            state           <= LOAD;
            wr_cnt          <= '0;
            bus.ld_ready    <= 1'b1;
            bus.instr       <= IW'(NOP_WORD);
            bus.instr_valid <= 1'b0;
            bus.load_err    <= 1'b0;
          end else begin
            bus.instr       <= mem[bus.pc_addr];
            bus.instr_valid <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_responder.sv
// Directed bench for imem_responder with a fetch scoreboard.
module tb_imem_responder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  int compared   = 0;
  int mismatched = 0;

  logic [11:0] exp_q [$];

  imem_responder_if #(.IW(12), .IMW(4), .LW(4)) bus ();

  imem_responder #(.IW(12), .IMW(4), .LW(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // Hard stop if the directed sequence ever stalls.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send_chunk(input logic [3:0] d, input logic last);
    @(negedge clk);
    bus.ld_valid = 1'b1;
    bus.ld_data  = d;
    bus.ld_last  = last;
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    bus.ld_valid = 1'b0;
    bus.ld_last  = 1'b0;
  endtask

  task automatic send_word(input logic [11:0] w, input logic last);
    send_chunk(w[11:8], 1'b0);
    send_chunk(w[7:4],  1'b0);
    send_chunk(w[3:0],  last);
  endtask

  // Waits (bounded) for the start pulse, then confirms it lasted one cycle.
  task automatic wait_start(input string tag);
    bit found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      bus.ld_valid = 1'b0;
      bus.ld_last  = 1'b0;
      if (bus.start === 1'b1) found = 1'b1;
    end
    check({tag, "_start_seen"}, 32'(found), 32'd1);
    @(negedge clk);
    check({tag, "_start_one_cycle"}, 32'(bus.start), 32'd0);
    check({tag, "_ready_low_in_run"}, 32'(bus.ld_ready), 32'd0);
  endtask

  // Drives a fetch address and scores the registered result one edge later.
  task automatic fetch(input logic [3:0] a, input logic [11:0] e);
    @(negedge clk);
    bus.pc_addr = a;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    check("fetch_valid", 32'(bus.instr_valid), 32'd1);
    if (exp_q.size() == 0) begin
      check("fetch_queue_empty", 32'd1, 32'd0);
    end else begin
      check($sformatf("fetch_addr%0d", a), 32'(bus.instr), 32'(exp_q.pop_front()));
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    bus.ld_valid = 1'b0;
    bus.ld_last  = 1'b0;
    bus.reload   = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic logic [11:0] ovf_word(input int i);
    logic [3:0] hi;
    logic [3:0] mid;
    hi  = 4'(i);
    mid = 4'(15 - i);
    return {hi, mid, 4'hA};
  endfunction

  initial begin
    bus.ld_valid = 1'b0;
    bus.ld_data  = '0;
    bus.ld_last  = 1'b0;
    bus.reload   = 1'b0;
    bus.pc_addr  = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // 1: asynchronous reset in the middle of a load
    send_chunk(4'h7, 1'b0);
    send_chunk(4'h8, 1'b0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    bus.ld_valid = 1'b0;
    #1;
    check("rst_instr", 32'(bus.instr), 32'h0);
    check("rst_instr_valid", 32'(bus.instr_valid), 32'd0);
    check("rst_start", 32'(bus.start), 32'd0);
    check("rst_ld_ready", 32'(bus.ld_ready), 32'd1);
    check("rst_load_err", 32'(bus.load_err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // 2: basic two-word load
    send_word(12'hABC, 1'b0);
    send_word(12'h123, 1'b1);
    wait_start("load");
    check("load_err_clean", 32'(bus.load_err), 32'd0);
    fetch(4'd1, 12'h123);
    fetch(4'd0, 12'hABC);

    // 3: load with ld_valid toggling every cycle
    do_reset();
    send_chunk(4'h4, 1'b0); idle_cycle();
    send_chunk(4'h5, 1'b0); idle_cycle();
    send_chunk(4'h6, 1'b0); idle_cycle();
    send_chunk(4'h7, 1'b0); idle_cycle();
    send_chunk(4'h8, 1'b0); idle_cycle();
    send_chunk(4'h9, 1'b1);
    wait_start("bp");
    fetch(4'd0, 12'h456);
    fetch(4'd1, 12'h789);
    for (int i = 0; i < 4; i++) begin
      send_chunk(4'hE, 1'b1);
      idle_cycle();
      check("run_ignore_ready", 32'(bus.ld_ready), 32'd0);
      check("run_ignore_start", 32'(bus.start), 32'd0);
    end
    check("run_ignore_err", 32'(bus.load_err), 32'd0);
    fetch(4'd0, 12'h456);
    fetch(4'd1, 12'h789);

    // 4: ld_last on the second chunk of word 1
    do_reset();
    send_word(12'hDEF, 1'b0);
    send_chunk(4'h1, 1'b0);
    send_chunk(4'h2, 1'b1);
    wait_start("badlast");
    check("badlast_err", 32'(bus.load_err), 32'd1);
    fetch(4'd0, 12'hDEF);
    fetch(4'd1, 12'h789);

    // 5: seventeen words into a sixteen-word memory
    do_reset();
    for (int i = 0; i < 16; i++) send_word(ovf_word(i), 1'b0);
    send_word(12'h555, 1'b1);
    wait_start("ovf");
    check("ovf_err", 32'(bus.load_err), 32'd1);
    fetch(4'd15, ovf_word(15));
    fetch(4'd0, ovf_word(0));
    fetch(4'd7, ovf_word(7));

    // 6: reload from RUN, then a one-word program
    @(negedge clk);
    bus.reload = 1'b1;
    @(posedge clk);
    #1;
    bus.reload = 1'b0;
    check("reload_instr", 32'(bus.instr), 32'h0);
    check("reload_instr_valid", 32'(bus.instr_valid), 32'd0);
    check("reload_load_err", 32'(bus.load_err), 32'd0);
    check("reload_ld_ready", 32'(bus.ld_ready), 32'd1);
    send_word(12'hFFF, 1'b1);
    wait_start("reload");
    check("reload_err_clean", 32'(bus.load_err), 32'd0);
    fetch(4'd0, 12'hFFF);
    fetch(4'd1, ovf_word(1));

    // Reset while running returns the fetch register to NOP immediately.
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("runrst_instr", 32'(bus.instr), 32'h0);
    check("runrst_instr_valid", 32'(bus.instr_valid), 32'd0);
    check("runrst_ld_ready", 32'(bus.ld_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
